// File: rtl/regfile_sb.sv
// Multi-ported integer register file with per-register pending-write scoreboard
// and optional same-cycle write-to-read bypass.
module regfile_sb #(
  parameter  int XLEN    = 32,
  parameter  int NREGS   = 32,
  parameter  int NRD     = 2,
  parameter  int NWR     = 1,
  parameter  int BYPASS  = 1,
  parameter  int ZERO_R0 = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NREGS-1:0]    busy_vec,
  output logic                wr_conflict
);

  logic [XLEN-1:0]  mem  [NREGS];
  logic [XLEN-1:0]  wval [NREGS];
  logic [NREGS-1:0] whit;
  logic [NREGS-1:0] busy_next;
  logic             alloc_ok;

  // Per-register write resolution; ascending port order lets the highest port win.
  always_comb begin
    whit = '0;
    for (int unsigned r = 0; r < NREGS; r++) wval[r] = '0;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (wr_en[k] && !(ZERO_R0 != 0 && wr_addr[k*AW +: AW] == '0)) begin
        whit[wr_addr[k*AW +: AW]] = 1'b1;
        wval[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    wr_conflict = 1'b0;
    for (int unsigned j = 0; j < NWR; j++) begin
      for (int unsigned k = j + 1; k < NWR; k++) begin
        if (wr_en[j] && wr_en[k] && wr_addr[j*AW +: AW] == wr_addr[k*AW +: AW])
          wr_conflict = 1'b1;
      end
    end
  end

  assign alloc_ok = alloc_en && !(ZERO_R0 != 0 && alloc_addr == '0);

  // Allocation outranks a retiring write so a back-to-back producer stays tracked.
  always_comb begin
    busy_next = busy_vec;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (alloc_ok && alloc_addr == AW'(r)) busy_next[r] = 1'b1;
      else if (whit[r])                      busy_next[r] = 1'b0;
    end
    if (ZERO_R0 != 0) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
      for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      busy_vec <= busy_next;
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (whit[r]) mem[r] <= wval[r];
      end
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    rd_data = '0;
    rd_busy = '0;
    a       = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      a = rd_addr[i*AW +: AW];
      if (ZERO_R0 != 0 && a == '0) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
      end else if (BYPASS != 0 && whit[a]) begin
        rd_data[i*XLEN +: XLEN] = wval[a];
        rd_busy[i]              = alloc_ok && alloc_addr == a;
      end else begin
        rd_data[i*XLEN +: XLEN] = mem[a];
        rd_busy[i]              = busy_vec[a];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb across default, dual-write and no-bypass/quad-read
// configurations; expected values queue up with the stimulus and are popped at each check.
module tb_regfile_sb;

  logic clk;
  logic rst_n;

  // Instance A: defaults (NRD=2, NWR=1, BYPASS=1, ZERO_R0=1)
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [0:0]  a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_alloc_en;
  logic [4:0]  a_alloc_addr;
  logic [31:0] a_busy;
  logic        a_conf;

  // Instance B: NWR=2
  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_addr;
  logic [63:0] b_wr_data;
  logic        b_alloc_en;
  logic [4:0]  b_alloc_addr;
  logic [31:0] b_busy;
  logic        b_conf;

  // Instance C: BYPASS=0, NRD=4, ZERO_R0=0
  logic [19:0]  c_rd_addr;
  logic [127:0] c_rd_data;
  logic [3:0]   c_rd_busy;
  logic [0:0]   c_wr_en;
  logic [4:0]   c_wr_addr;
  logic [31:0]  c_wr_data;
  logic         c_alloc_en;
  logic [4:0]   c_alloc_addr;
  logic [31:0]  c_busy;
  logic         c_conf;

  regfile_sb u_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .alloc_en(a_alloc_en),
    .alloc_addr(a_alloc_addr), .busy_vec(a_busy), .wr_conflict(a_conf)
  );

  regfile_sb #(.NWR(2)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .alloc_en(b_alloc_en),
    .alloc_addr(b_alloc_addr), .busy_vec(b_busy), .wr_conflict(b_conf)
  );

  regfile_sb #(.NRD(4), .BYPASS(0), .ZERO_R0(0)) u_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .alloc_en(c_alloc_en),
    .alloc_addr(c_alloc_addr), .busy_vec(c_busy), .wr_conflict(c_conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic exp_push(input logic [127:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [127:0] obs);
    logic [127:0] e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0; a_alloc_en = 1'b0; a_alloc_addr = '0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_alloc_en = 1'b0; b_alloc_addr = '0;
    c_rd_addr = '0; c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0; c_alloc_en = 1'b0; c_alloc_addr = '0;
    #1;
    exp_push(128'h0); check("reset_busy_vec", a_busy);
    exp_push(128'h0); check("reset_rd_data",  a_rd_data);
    exp_push(128'h0); check("reset_conflict", b_conf);
    tick();
    rst_n = 1'b1;

    // Scoreboard: alloc r7 in cycle 0, write in cycle 3
    a_alloc_en = 1'b1; a_alloc_addr = 5'd7; a_rd_addr = {5'd0, 5'd7};
    #1;
    exp_push(128'h0); check("alloc_c0_rd_busy", a_rd_busy);
    tick();
    a_alloc_en = 1'b0;
    #1;
    exp_push(128'h1); check("alloc_c1_busy7", a_busy[7]);
    exp_push(128'h1); check("alloc_c1_rd_busy", a_rd_busy[0]);
    tick(); tick();
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'hA5A5A5A5;
    #1;
    exp_push(128'hA5A5A5A5); check("bypass_c3_data", a_rd_data[31:0]);
    exp_push(128'h0);        check("bypass_c3_rd_busy", a_rd_busy[0]);
    exp_push(128'h1);        check("bypass_c3_busy7_still", a_busy[7]);
    tick();
    a_wr_en = 1'b0;
    #1;
    exp_push(128'h0);        check("c4_busy7_clear", a_busy[7]);
    exp_push(128'hA5A5A5A5); check("c4_stored_r7", a_rd_data[31:0]);

    // Simultaneous alloc + write of r9, read on port 1
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h99887766;
    a_alloc_en = 1'b1; a_alloc_addr = 5'd9; a_rd_addr = {5'd9, 5'd7};
    #1;
    exp_push(128'h99887766); check("allocwr_bypass_data", a_rd_data[63:32]);
    exp_push(128'h1);        check("allocwr_rd_busy", a_rd_busy[1]);
    tick();
    a_wr_en = 1'b0; a_alloc_en = 1'b0;
    #1;
    exp_push(128'h1);        check("allocwr_busy9", a_busy[9]);
    exp_push(128'h99887766); check("allocwr_stored_r9", a_rd_data[63:32]);

    // r0 guard
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h1234;
    a_alloc_en = 1'b1; a_alloc_addr = 5'd0; a_rd_addr = {5'd9, 5'd0};
    #1;
    exp_push(128'h0); check("r0_bypass_data", a_rd_data[31:0]);
    exp_push(128'h0); check("r0_rd_busy", a_rd_busy[0]);
    tick();
    a_wr_en = 1'b0; a_alloc_en = 1'b0;
    #1;
    exp_push(128'h0); check("r0_busy_vec0", a_busy[0]);
    exp_push(128'h0); check("r0_stored", a_rd_data[31:0]);

    // Mid-run reset with r5 busy and holding DEADBEEF
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
    a_alloc_en = 1'b1; a_alloc_addr = 5'd5;
    tick();
    a_wr_en = 1'b0; a_alloc_en = 1'b0; a_rd_addr = {5'd9, 5'd5};
    #1;
    exp_push(128'h1);        check("pre_reset_busy5", a_busy[5]);
    exp_push(128'hDEADBEEF); check("pre_reset_r5", a_rd_data[31:0]);
    rst_n = 1'b0;
    #1;
    exp_push(128'h0); check("midreset_rd_data", a_rd_data);
    exp_push(128'h0); check("midreset_rd_busy", a_rd_busy);
    exp_push(128'h0); check("midreset_busy_vec", a_busy);
    tick();
    rst_n = 1'b1;
    tick();
    exp_push(128'h0); check("post_reset_r5", a_rd_data[31:0]);

    // Dual write port collision
    b_wr_en = 2'b11; b_wr_addr = {5'd3, 5'd3}; b_wr_data = {32'h22, 32'h11}; b_rd_addr = {5'd0, 5'd3};
    #1;
    exp_push(128'h1);  check("collide_conflict", b_conf);
    exp_push(128'h22); check("collide_bypass", b_rd_data[31:0]);
    tick();
    b_wr_addr = {5'd5, 5'd4}; b_wr_data = {32'h55, 32'h44};
    #1;
    exp_push(128'h0);  check("distinct_conflict", b_conf);
    exp_push(128'h22); check("collide_stored_r3", b_rd_data[31:0]);
    tick();
    b_wr_en = 2'b00; b_rd_addr = {5'd5, 5'd4};
    #1;
    exp_push({64'h0, 32'h55, 32'h44}); check("dual_stored_r4_r5", b_rd_data);

    // No bypass, four read ports on r12
    c_wr_en = 1'b1; c_wr_addr = 5'd12; c_wr_data = 32'h11111111;
    tick();
    c_wr_en = 1'b0; c_alloc_en = 1'b1; c_alloc_addr = 5'd12;
    tick();
    c_alloc_en = 1'b0;
    c_wr_en = 1'b1; c_wr_data = 32'hCAFEF00D; c_rd_addr = {4{5'd12}};
    #1;
    exp_push({4{32'h11111111}}); check("nobyp_old_value", c_rd_data);
    exp_push(128'hF);            check("nobyp_busy_held", c_rd_busy);
    tick();
    c_wr_en = 1'b0;
    #1;
    exp_push({4{32'hCAFEF00D}}); check("nobyp_new_value", c_rd_data);
    exp_push(128'h0);            check("nobyp_busy_clear", c_rd_busy);

    // ZERO_R0 = 0: r0 is ordinary
    c_wr_en = 1'b1; c_wr_addr = 5'd0; c_wr_data = 32'h1234;
    c_alloc_en = 1'b1; c_alloc_addr = 5'd0; c_rd_addr = {15'd0, 5'd0};
    tick();
    c_wr_en = 1'b0; c_alloc_en = 1'b0;
    #1;
    exp_push(128'h1234); check("r0_ordinary_data", c_rd_data[31:0]);
    exp_push(128'h1);    check("r0_ordinary_busy", c_busy[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-ported integer register file with a per-register scoreboard (pending-write bits) and optional write-to-read bypass. It replaces the fixed 2-read/1-write file in the decode/writeback path of the core. Issue logic allocates a destination register, which marks it busy. Writeback clears the busy bit when it writes the register. Decode reads operands and busy status in the same cycle.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of registers; power of two, ≥ 2; AW = $clog2(NREGS)
- NRD, 2, number of read ports, ≥ 1
- NWR, 1, number of write ports, ≥ 1
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
- ZERO_R0, 1, 1 = register 0 hardwired to zero and never busy

- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- rd_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  output  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rd_busy  output  NRD  port i's register has a pending write
- wr_en  input  NWR  write enables
- wr_addr  input  NWR*AW  write addresses
- wr_data  input  NWR*XLEN  write data
- alloc_en  input  1  mark alloc_addr busy
- alloc_addr  input  AW  register to allocate
- busy_vec  output  NREGS  registered scoreboard, bit r = register r pending
- wr_conflict  output  1  two or more enabled write ports target the same register this cycle

## Operation
- Storage is an NREGS × XLEN array plus an NREGS-bit busy vector.
- Reset (rst_n low, asynchronous): all registers = 0 and busy_vec = 0. The state is held until the first rising edge after rst_n deasserts. Reset mid-operation drops all pending allocations.
- Write, per edge: each port with wr_en[k] and a nonzero effective address stores wr_data[k].
  - Same-address collision: the highest-numbered port wins.
  - wr_conflict is combinational and asserted whenever a collision occurs.
- Busy update, per edge, for each register r:
  - Set if alloc_en and alloc_addr == r.
  - Else cleared if any enabled write targets r.
  - Else held.
  - Alloc and write to the same r in the same cycle: alloc wins and the bit stays/becomes 1. This covers a new producer issued as the old one retires.
- Read, combinational per port i:
  - If ZERO_R0 and rd_addr == 0: data = 0, busy = 0.
  - Else, if BYPASS and some enabled write hits rd_addr: data = winning port's wr_data. rd_busy = 0 unless alloc_en targets the same address this cycle.
  - Else: data = stored value, rd_busy = busy_vec[rd_addr].
- ZERO_R0 = 1:
  - Writes to r0 are discarded.
  - Alloc of r0 is ignored.
  - busy_vec[0] is constant 0.
- ZERO_R0 = 0: r0 is an ordinary register.
- Writing a register that is not busy is legal; it updates data and leaves busy at 0.
- Allocating an already-busy register is legal; the bit stays 1.
- busy_vec carries no count. A second alloc before writeback is cleared by the first matching write.

## Timing
- Read data and rd_busy: zero-cycle combinational from rd_addr, and from wr_*/alloc_* when BYPASS = 1.
- Write to read without bypass: stored value is visible on the cycle after the edge (latency 1).
- alloc to busy_vec / rd_busy: 1 cycle; the bit is set after the edge.
- Write to busy clear: 1 cycle. With BYPASS = 1, rd_busy drops in the write cycle itself.
- busy_vec is a pure register output with no combinational path from inputs.
- Reset values: busy_vec = 0, rd_busy = 0, rd_data = 0 for all ports, wr_conflict = 0 provided wr_en = 0.

## Test plan
- Reset, default params: assert rst_n low mid-run with r5 busy and holding 0xDEADBEEF. Required: immediately rd_data = 0, rd_busy = 0, busy_vec = 0. After release, read r5 → 0.
- r0 guard: write 0x1234 to r0 and alloc r0. Required: reading r0 → 0, rd_busy[0] = 0, busy_vec[0] = 0. Repeat with ZERO_R0 = 0: r0 reads 0x1234.
- Scoreboard: alloc r7 in cycle 0 → busy_vec[7] = 1 from cycle 1. Write r7 = 0xA5A5A5A5 in cycle 3. Required: with BYPASS = 1, port 0 reads 0xA5A5A5A5 with rd_busy = 0 in cycle 3; busy_vec[7] = 0 from cycle 4.
- Simultaneous alloc + write of r9: required busy_vec[9] = 1 next cycle and data = written value.
- NWR = 2 collision: both ports write r3 with 0x11 and 0x22. Required: wr_conflict = 1 that cycle; r3 reads 0x22 afterwards.
- BYPASS = 0, NRD = 4: write r12 = 0xCAFEF00D. Required: all four ports reading r12 show the old value in the write cycle and 0xCAFEF00D the next cycle.
